// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: turns a 1-cycle-latency FIFO read port
// into a valid/ready stream through a 2-entry output buffer.
module fifo_stream_reader #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             fifo_empty,
   output logic             fifo_read_enable,
   input  logic [WIDTH-1:0] fifo_read_data,
   output logic             stream_valid,
   input  logic             stream_ready,
   output logic [WIDTH-1:0] stream_data,
   output logic [1:0]       buffer_level
);

   logic [WIDTH-1:0] entry0_q, entry1_q;
   logic [WIDTH-1:0] entry0_n, entry1_n;
   logic [1:0]       level_q, level_n;
   logic             inflight_q;
   logic             valid_q;
   logic             pop;
   logic [2:0]       occ;

   assign stream_valid = valid_q;
   assign stream_data  = entry0_q;
   assign buffer_level = level_q;

   // Read issue plus buffer next-state: shift on pop, then land the returning word.
   always_comb begin
      pop      = valid_q & stream_ready;
      occ      = {1'b0, level_q} + {2'b00, inflight_q};
      entry0_n = entry0_q;
      entry1_n = entry1_q;
      level_n  = level_q;
      fifo_read_enable = ~reset & ~fifo_empty
                         & ((occ < 3'd2) | pop);
      if (pop) begin
         entry0_n = entry1_q;
         level_n  = level_q - 2'd1;
      end
      if (inflight_q) begin
         if (level_n == 2'd0)
            entry0_n = fifo_read_data;
         else
            entry1_n = fifo_read_data;
         level_n = level_n + 2'd1;
      end
   end

   // Buffer, level, in-flight flag and registered valid.
   always_ff @(posedge clock) begin
      if (reset) begin
         entry0_q   <= '0;
         entry1_q   <= '0;
         level_q    <= 2'd0;
         inflight_q <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         entry0_q   <= entry0_n;
         entry1_q   <= entry1_n;
         level_q    <= level_n;
         inflight_q <= fifo_read_enable;
         valid_q    <= (level_n != 2'd0);
      end
   end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: upstream FIFO model, scoreboard of
// expected words in push order, directed and random phases.
module tb_fifo_stream_reader;

   logic       clock = 1'b0;
   logic       reset;
   logic       fifo_empty;
   logic       fifo_read_enable;
   logic [7:0] fifo_read_data = 8'h00;
   logic       stream_valid;
   logic       stream_ready;
   logic [7:0] stream_data;
   logic [1:0] buffer_level;

   logic [7:0] mem [256];
   logic [7:0] wr_ptr = 8'd0;
   logic [7:0] rd_ptr = 8'd0;
   logic       fifo_flush = 1'b0;
   logic [7:0] sb [$];

   int n_cmp = 0;
   int n_bad = 0;
   int delivered = 0;
   logic       hold_prev = 1'b0;
   logic [7:0] prev_d = 8'h00;

   fifo_stream_reader #(.WIDTH(8)) dut (
      .clock            (clock),
      .reset            (reset),
      .fifo_empty       (fifo_empty),
      .fifo_read_enable (fifo_read_enable),
      .fifo_read_data   (fifo_read_data),
      .stream_valid     (stream_valid),
      .stream_ready     (stream_ready),
      .stream_data      (stream_data),
      .buffer_level     (buffer_level)
   );

   always #5 clock = ~clock;

   assign fifo_empty = (wr_ptr == rd_ptr);

   // Upstream FIFO: data appears one cycle after the pop strobe.
   always @(posedge clock) begin
      if (fifo_flush) begin
         rd_ptr <= wr_ptr;
      end else if (fifo_read_enable) begin
         fifo_read_data <= mem[rd_ptr];
         rd_ptr <= rd_ptr + 8'd1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic push(input logic [7:0] w);
      mem[wr_ptr] = w;
      wr_ptr = wr_ptr + 8'd1;
      sb.push_back(w);
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic drain(input int bound);
      for (int i = 0; i < bound; i++) begin
         if (sb.size() == 0) break;
         cyc();
      end
      chk("drain_left", 32'(sb.size()), 0);
   endtask

   // Stream monitor: order, no loss/dup, stability under backpressure, no read when empty.
   always @(negedge clock) begin
      if (reset) begin
         hold_prev = 1'b0;
      end else begin
         if (fifo_empty)
            chk("rd_when_empty", 32'(fifo_read_enable), 0);
         if (hold_prev) begin
            chk("hold_valid", 32'(stream_valid), 1);
            chk("hold_data", 32'(stream_data), 32'(prev_d));
         end
         if (stream_valid && stream_ready) begin
            chk("word_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0)
               chk("word_order", 32'(stream_data), 32'(sb.pop_front()));
            delivered++;
         end
         hold_prev = stream_valid && !stream_ready;
         prev_d = stream_data;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int reads;
      int d0;
      int npush;

      // Reset with a non-empty FIFO
      reset = 1'b1;
      stream_ready = 1'b0;
      mem[wr_ptr] = 8'h99;
      wr_ptr = wr_ptr + 8'd1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         chk("rst_rd_en", 32'(fifo_read_enable), 0);
         cyc();
      end
      fifo_flush = 1'b1;
      cyc();
      reset = 1'b0;
      fifo_flush = 1'b0;
      @(negedge clock);
      chk("rst_valid", 32'(stream_valid), 0);
      chk("rst_data", 32'(stream_data), 0);
      chk("rst_level", 32'(buffer_level), 0);
      chk("rst_rd_idle", 32'(fifo_read_enable), 0);
      cyc();

      // Single word: read at N, valid at N+2 only
      stream_ready = 1'b1;
      push(8'hA5);
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         chk("single_rd", 32'(fifo_read_enable), 32'(i == 0));
         chk("single_valid", 32'(stream_valid), 32'(i == 2));
         if (i == 2)
            chk("single_data", 32'(stream_data), 32'hA5);
         cyc();
      end

      // Streaming 0..7 at full rate
      for (int k = 0; k < 8; k++)
         push(8'(k));
      for (int i = 0; i < 12; i++) begin
         @(negedge clock);
         chk("strm_rd", 32'(fifo_read_enable), 32'(i < 8));
         chk("strm_valid", 32'(stream_valid), 32'(i >= 2 && i < 10));
         if (i >= 2 && i < 10)
            chk("strm_data", 32'(stream_data), 32'(i - 2));
         cyc();
      end

      // Backpressure: only two reads, head held
      stream_ready = 1'b0;
      for (int k = 0; k < 6; k++)
         push(8'(8'h10 + k));
      reads = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         if (fifo_read_enable) reads++;
         if (i >= 3) begin
            chk("bp_level", 32'(buffer_level), 2);
            chk("bp_valid", 32'(stream_valid), 1);
            chk("bp_data", 32'(stream_data), 32'h10);
         end
         cyc();
      end
      chk("bp_reads", 32'(reads), 2);
      d0 = delivered;
      stream_ready = 1'b1;
      drain(40);
      chk("bp_count", 32'(delivered - d0), 6);

      // Simultaneous pop and capture
      stream_ready = 1'b0;
      push(8'h20);
      cyc();
      push(8'h21);
      @(negedge clock);
      chk("sim_rd", 32'(fifo_read_enable), 1);
      cyc();
      stream_ready = 1'b1;
      @(negedge clock);
      chk("sim_lvl0", 32'(buffer_level), 1);
      chk("sim_head0", 32'(stream_data), 32'h20);
      cyc();
      @(negedge clock);
      chk("sim_head1", 32'(stream_data), 32'h21);
      chk("sim_lvl1", 32'(buffer_level), 1);
      cyc();
      drain(20);

      // Reset mid-stream with buffered and in-flight words
      stream_ready = 1'b0;
      for (int k = 0; k < 4; k++)
         push(8'(8'h30 + k));
      cyc();
      cyc();
      cyc();
      @(negedge clock);
      chk("mid_level2", 32'(buffer_level), 2);
      cyc();
      stream_ready = 1'b1;
      @(negedge clock);
      chk("mid_rd_on_pop", 32'(fifo_read_enable), 1);
      cyc();
      stream_ready = 1'b0;
      reset = 1'b1;
      fifo_flush = 1'b1;
      sb.delete();
      @(negedge clock);
      chk("mid_pre_level", 32'(buffer_level), 1);
      chk("mid_rst_rd", 32'(fifo_read_enable), 0);
      cyc();
      reset = 1'b0;
      fifo_flush = 1'b0;
      @(negedge clock);
      chk("mid_valid", 32'(stream_valid), 0);
      chk("mid_level", 32'(buffer_level), 0);
      chk("mid_data", 32'(stream_data), 0);
      cyc();
      d0 = delivered;
      stream_ready = 1'b1;
      push(8'h40);
      push(8'h41);
      push(8'h42);
      drain(20);
      chk("mid_after", 32'(delivered - d0), 3);

      // Random pushes and random backpressure
      d0 = delivered;
      npush = 0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(2) == 0 && 8'(wr_ptr - rd_ptr) < 8'd200) begin
            push(8'($urandom_range(255)));
            npush++;
         end
         stream_ready = ($urandom_range(3) != 0);
         cyc();
      end
      stream_ready = 1'b1;
      drain(400);
      chk("rand_count", 32'(delivered - d0), 32'(npush));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
